// File: rtl/dll_ctrl_pkg.sv
// Shared types and constants for the DLL calibration controller.
package dll_ctrl_pkg;

  localparam int ADJ_W               = 8;
  localparam int DEF_RST_CYCLES      = 16;
  localparam int DEF_LOCK_TIMEOUT    = 255;
  localparam int DEF_BLANK_CYCLES    = 2;
  localparam int DEF_MAX_RETRY       = 3;
  // Lock acquisition time of the behavioural DLL after reset release.
  localparam int DLL_LOCK_CYCLES     = 100;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_ERROR     = 3'd4
  } dll_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dll_lock_timer.sv
// Up-counter shared by the RESET hold and the WAIT_LOCK supervision window.
// It stops at `limit`; `clear` restarts it from zero on the next edge.
module dll_lock_timer
  import dll_ctrl_pkg::*;
#(
  parameter int CW           = 9,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          blank_done,
  output logic          limit_hit
);

  assign limit_hit  = (count == limit);
  assign blank_done = (count >= CW'(BLANK_CYCLES));

  // Count up while enabled, holding at the limit until cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !limit_hit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dll_cal_ctrl.sv
// DLL calibration sequencer: accepts delay configurations, drives the DLL
// through reset and lock acquisition, supervises lock with bounded retries
// and reports status plus a count of unsolicited lock losses.
//
// Handshake: a configuration is taken on any edge where io_cfg_valid and
// io_cfg_ready are both high. io_cfg_ready depends only on state (high in
// IDLE, LOCKED and ERROR), so it never depends on io_cfg_valid.
module dll_cal_ctrl
  import dll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_cfg_valid,
  output logic             io_cfg_ready,
  input  logic [ADJ_W-1:0] io_cfg_adj,
  input  logic [ADJ_W-1:0] io_cfg_madj,
  output logic             io_dll_reset,
  output logic [ADJ_W-1:0] io_adj,
  output logic [ADJ_W-1:0] io_madj,
  input  logic             io_lock,
  output logic             io_locked,
  output logic             io_busy,
  output logic             io_err,
  output logic [7:0]       io_relock_cnt,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(max_int(RST_CYCLES, LOCK_TIMEOUT)) + 1;
  localparam int RW = max_int(1, $clog2(MAX_RETRY + 1));

  dll_state_e       state, state_nxt;
  logic [RW-1:0]    retry, retry_nxt;
  logic [ADJ_W-1:0] adj_nxt, madj_nxt;
  logic [7:0]       relock_nxt;
  logic             dll_reset_nxt, err_nxt, locked_nxt, busy_nxt;
  logic             accept, cfg_legal;
  logic             timer_clr, timer_en, blank_done, limit_hit;
  logic [CW-1:0]    timer_limit, timer_count;

  assign io_cfg_ready = (state == ST_IDLE) || (state == ST_LOCKED) || (state == ST_ERROR);
  assign accept       = io_cfg_valid && io_cfg_ready;
  assign cfg_legal    = (io_cfg_madj != '0);
  assign dbg_state    = state;
  assign timer_limit  = (state == ST_RESET) ? CW'(RST_CYCLES - 1) : CW'(LOCK_TIMEOUT - 1);

  dll_lock_timer #(
    .CW           (CW),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (timer_clr),
    .enable     (timer_en),
    .limit      (timer_limit),
    .count      (timer_count),
    .blank_done (blank_done),
    .limit_hit  (limit_hit)
  );

  // Next-state and next-output decode; an accepted cfg overrides the state's own action.
  always_comb begin
    state_nxt     = state;
    retry_nxt     = retry;
    adj_nxt       = io_adj;
    madj_nxt      = io_madj;
    relock_nxt    = io_relock_cnt;
    dll_reset_nxt = io_dll_reset;
    err_nxt       = io_err;
    locked_nxt    = 1'b0;
    timer_clr     = 1'b1;
    timer_en      = 1'b0;

    case (state)
      ST_RESET: begin
        dll_reset_nxt = 1'b1;
        timer_clr     = 1'b0;
        timer_en      = 1'b1;
        if (limit_hit) begin
          dll_reset_nxt = 1'b0;
          state_nxt     = ST_WAIT_LOCK;
          timer_clr     = 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        timer_clr = 1'b0;
        timer_en  = 1'b1;
        // Lock beats a simultaneous timeout; stale lock is ignored during blanking.
        if (blank_done && io_lock) begin
          state_nxt  = ST_LOCKED;
          locked_nxt = 1'b1;
        end else if (limit_hit) begin
          timer_clr     = 1'b1;
          dll_reset_nxt = 1'b1;
          if (retry < RW'(MAX_RETRY)) begin
            retry_nxt = retry + 1'b1;
            state_nxt = ST_RESET;
          end else begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        locked_nxt = io_lock;
        if (!accept && !io_lock) begin
          relock_nxt = (io_relock_cnt == 8'hFF) ? io_relock_cnt : io_relock_cnt + 8'd1;
          retry_nxt  = '0;
          state_nxt  = ST_WAIT_LOCK;
        end
      end
      ST_ERROR: begin
        dll_reset_nxt = 1'b1;
      end
      default: begin
        dll_reset_nxt = 1'b1;
      end
    endcase

    if (accept) begin
      if (!cfg_legal) begin
        state_nxt     = ST_ERROR;
        err_nxt       = 1'b1;
        dll_reset_nxt = 1'b1;
        locked_nxt    = 1'b0;
      end else begin
        err_nxt   = 1'b0;
        retry_nxt = '0;
        if ((state != ST_LOCKED) || (io_cfg_madj != io_madj)) begin
          state_nxt     = ST_RESET;
          adj_nxt       = io_cfg_adj;
          madj_nxt      = io_cfg_madj;
          dll_reset_nxt = 1'b1;
          locked_nxt    = 1'b0;
        end else if (io_cfg_adj != io_adj) begin
          // Same denominator: the DLL retunes in place without a reset.
          state_nxt  = ST_WAIT_LOCK;
          adj_nxt    = io_cfg_adj;
          locked_nxt = 1'b0;
        end
      end
    end

    busy_nxt = (state_nxt == ST_RESET) || (state_nxt == ST_WAIT_LOCK);
  end

  // Register state, DLL controls and status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      retry         <= '0;
      io_dll_reset  <= 1'b1;
      io_adj        <= '0;
      io_madj       <= ADJ_W'(1);
      io_locked     <= 1'b0;
      io_busy       <= 1'b0;
      io_err        <= 1'b0;
      io_relock_cnt <= '0;
    end else begin
      state         <= state_nxt;
      retry         <= retry_nxt;
      io_dll_reset  <= dll_reset_nxt;
      io_adj        <= adj_nxt;
      io_madj       <= madj_nxt;
      io_locked     <= locked_nxt;
      io_busy       <= busy_nxt;
      io_err        <= err_nxt;
      io_relock_cnt <= relock_nxt;
    end
  end

endmodule

// File: tb/tb_dll_cal_ctrl.sv
// Bench for dll_cal_ctrl with a behavioural DLL model.
module tb_dll_cal_ctrl;
  import dll_ctrl_pkg::*;

  localparam int W = 32;

  // Clock and reset
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_adj   = '0;
  logic [7:0] cfg_madj  = '0;
  logic       cfg_ready, dll_reset, lock, locked, busy, err;
  logic [7:0] adj, madj, relock_cnt;
  logic [2:0] dbg_state;

  dll_cal_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .io_cfg_valid  (cfg_valid),
    .io_cfg_ready  (cfg_ready),
    .io_cfg_adj    (cfg_adj),
    .io_cfg_madj   (cfg_madj),
    .io_dll_reset  (dll_reset),
    .io_adj        (adj),
    .io_madj       (madj),
    .io_lock       (lock),
    .io_locked     (locked),
    .io_busy       (busy),
    .io_err        (err),
    .io_relock_cnt (relock_cnt),
    .dbg_state     (dbg_state)
  );

  // Behavioural DLL: locks DLL_LOCK_CYCLES after reset release or an adj change.
  int         mcnt       = 0;
  logic       mlock      = 1'b0;
  logic [7:0] adj_q      = '0;
  logic       never_lock = 1'b0;
  logic       drop       = 1'b0;

  always @(posedge clock) begin
    adj_q <= adj;
    if (dll_reset || never_lock || (adj != adj_q)) begin
      mcnt  <= 0;
      mlock <= 1'b0;
    end else if (mcnt == DLL_LOCK_CYCLES - 1) begin
      mlock <= 1'b1;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  assign lock = mlock & ~drop;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [W-1:0] make_snap(input logic [2:0] st, input logic l, input logic b,
                                             input logic e, input logic r, input logic rd,
                                             input logic [7:0] a, input logic [7:0] m,
                                             input logic [7:0] c);
    return {st, l, b, e, r, rd, a, m, c};
  endfunction

  function automatic logic [W-1:0] dut_snap();
    return {dbg_state, locked, busy, err, dll_reset, cfg_ready, adj, madj, relock_cnt};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_cmp++;
    if (val < lo || val > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, val, lo, hi, $time);
    end
  endtask

  // Status snapshot taken each time the controller settles in LOCKED or ERROR.
  logic [2:0] prev_st = 3'(ST_IDLE);
  always @(negedge clock) begin
    if (reset_n && (dbg_state == ST_LOCKED || dbg_state == ST_ERROR) && dbg_state != prev_st) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got %h with no expected entry (t=%0t)", dut_snap(), $time);
      end else begin
        check("status_event", dut_snap(), exp_q.pop_front());
      end
    end
    prev_st = dbg_state;
  end

  // Driver tasks
  task automatic send_cfg(input logic [7:0] a, input logic [7:0] m);
    int n;
    n = 0;
    @(negedge clock);
    while (!cfg_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("cfg_ready_before_send", W'(cfg_ready), W'(1));
    cfg_valid = 1'b1;
    cfg_adj   = a;
    cfg_madj  = m;
    @(posedge clock);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
    int n;
    n = 0;
    while (dbg_state != tgt && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, W'(dbg_state), W'(tgt));
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int n, pulses;
    logic [2:0] pst;

    repeat (3) @(negedge clock);
    check("reset_values", dut_snap(), make_snap(ST_IDLE, 0, 0, 0, 1, 1, 8'd0, 8'd1, 8'd0));
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_after_release", dut_snap(), make_snap(ST_IDLE, 0, 0, 0, 1, 1, 8'd0, 8'd1, 8'd0));

    // Bring-up
    exp_q.push_back(make_snap(ST_LOCKED, 1, 0, 0, 0, 1, 8'd32, 8'd128, 8'd0));
    send_cfg(8'd32, 8'd128);
    @(negedge clock);
    n = 0;
    while (dbg_state == ST_RESET && dll_reset && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("rst_pulse_len", W'(n), W'(16));
    check("dll_reset_released", W'(dll_reset), W'(0));
    n = 0;
    while (!locked && n < 400) begin
      @(negedge clock);
      n++;
    end
    check_range("lock_latency", n, 101, 103);
    check("bringup_status", W'({busy, adj, madj}), W'({1'b0, 8'd32, 8'd128}));

    // Adj retune without DLL reset
    exp_q.push_back(make_snap(ST_LOCKED, 1, 0, 0, 0, 1, 8'd64, 8'd128, 8'd0));
    send_cfg(8'd64, 8'd128);
    check("retune_entry", W'({dbg_state, adj, dll_reset, locked}),
          W'({3'(ST_WAIT_LOCK), 8'd64, 1'b0, 1'b0}));
    n = 0;
    pulses = 0;
    while (dbg_state != ST_LOCKED && n < 400) begin
      @(negedge clock);
      n++;
      if (dll_reset) pulses++;
    end
    check("retune_no_reset", W'(pulses), W'(0));
    check_range("retune_relock_time", n, 100, 106);
    check("retune_relock_cnt", W'(relock_cnt), W'(0));

    // Identical cfg is consumed with no change
    send_cfg(8'd64, 8'd128);
    repeat (4) @(negedge clock);
    check("identical_cfg", W'({dbg_state, busy, adj, madj, dll_reset}),
          W'({3'(ST_LOCKED), 1'b0, 8'd64, 8'd128, 1'b0}));

    // Unsolicited lock losses, saturating count
    for (int i = 1; i <= 300; i++) begin
      exp_q.push_back(make_snap(ST_LOCKED, 1, 0, 0, 0, 1, 8'd64, 8'd128,
                                (i > 255) ? 8'd255 : 8'(i)));
      @(negedge clock);
      drop = 1'b1;
      @(posedge clock);
      #1 drop = 1'b0;
      n = 0;
      while (dbg_state != ST_LOCKED && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (i == 1) check("blank_relock_len", W'(n), W'(4));
    end
    check("relock_saturated", W'(relock_cnt), W'(255));

    // Illegal cfg from LOCKED
    exp_q.push_back(make_snap(ST_ERROR, 0, 0, 1, 1, 1, 8'd64, 8'd128, 8'd255));
    send_cfg(8'd77, 8'd0);
    @(negedge clock);
    check("illegal_cfg", W'({dbg_state, err, dll_reset, cfg_ready, adj, madj}),
          W'({3'(ST_ERROR), 1'b1, 1'b1, 1'b1, 8'd64, 8'd128}));

    // Legal cfg leaves ERROR
    exp_q.push_back(make_snap(ST_LOCKED, 1, 0, 0, 0, 1, 8'd64, 8'd128, 8'd255));
    send_cfg(8'd64, 8'd128);
    @(negedge clock);
    check("err_cleared_after_illegal", W'(err), W'(0));
    wait_state(ST_LOCKED, 400, "relock_after_error");

    // Timeout and retry exhaustion
    exp_q.push_back(make_snap(ST_ERROR, 0, 0, 1, 1, 1, 8'd10, 8'd200, 8'd255));
    never_lock = 1'b1;
    send_cfg(8'd10, 8'd200);
    pulses = 0;
    pst = 3'(ST_LOCKED);
    n = 0;
    while (dbg_state != ST_ERROR && n < 3000) begin
      if (dbg_state == ST_RESET && pst != ST_RESET) pulses++;
      pst = dbg_state;
      @(negedge clock);
      n++;
    end
    check("timeout_error_state", W'(dbg_state), W'(ST_ERROR));
    check("timeout_reset_pulses", W'(pulses), W'(4));
    check("timeout_status", W'({err, dll_reset, cfg_ready}), W'(3'b111));

    // Recovery clears the error
    never_lock = 1'b0;
    exp_q.push_back(make_snap(ST_LOCKED, 1, 0, 0, 0, 1, 8'd10, 8'd200, 8'd255));
    send_cfg(8'd10, 8'd200);
    @(negedge clock);
    check("err_cleared_after_timeout", W'(err), W'(0));
    wait_state(ST_LOCKED, 400, "relock_after_timeout");

    // Asynchronous reset in WAIT_LOCK
    send_cfg(8'd20, 8'd50);
    wait_state(ST_WAIT_LOCK, 100, "reach_wait_lock");
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check("async_reset_values", dut_snap(), make_snap(ST_IDLE, 0, 0, 0, 1, 1, 8'd0, 8'd1, 8'd0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_after_async_reset", dut_snap(), make_snap(ST_IDLE, 0, 0, 0, 1, 1, 8'd0, 8'd1, 8'd0));

    check("exp_q_drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dll_cal_ctrl.md
Name: dll_cal_ctrl

Overview:
- Sequencer in front of the behavioural DLL (ports io_dll_reset, io_adj, io_madj, io_lock).
- Accepts delay configuration requests over a valid/ready handshake, then runs the DLL through reset and lock acquisition.
- Supervises lock with a timeout, retries a bounded number of times, and reports locked/busy/error status plus a relock event count.
- Runs on the DLL's reference clock; it is the only driver of the DLL control inputs.

Parameters:
- RST_CYCLES, 16: cycles io_dll_reset is held high per reset sequence (≥1).
- LOCK_TIMEOUT, 255: cycles allowed in WAIT_LOCK before a retry; must exceed the DLL lock time of 100 cycles plus margin.
- BLANK_CYCLES, 2: cycles after entering WAIT_LOCK during which io_lock is ignored (stale lock).
- MAX_RETRY, 3: timeouts tolerated before ERROR.

Ports:
- clock  in  1: reference clock, same net as DLL io_clock_ref.
- reset_n  in  1: asynchronous active-low reset.
- io_cfg_valid  in  1: configuration request.
- io_cfg_ready  out  1: controller can accept a request.
- io_cfg_adj  in  8: requested delay numerator.
- io_cfg_madj  in  8: requested delay denominator; 0 is illegal.
- io_dll_reset  out  1: to DLL io_dll_reset.
- io_adj  out  8: to DLL io_adj.
- io_madj  out  8: to DLL io_madj.
- io_lock  in  1: from DLL io_lock.
- io_locked  out  1: DLL locked and controller in LOCKED.
- io_busy  out  1: state is RESET or WAIT_LOCK.
- io_err  out  1: sticky error (timeout exhaustion or illegal cfg).
- io_relock_cnt  out  8: saturating count of unsolicited lock losses.

Behaviour:
- Clock and reset: one clock, `clock`. `reset_n` is asynchronous, active-low, and is the only reset.
- Reset values:
  - state=IDLE, io_dll_reset=1, io_adj=0, io_madj=1, io_cfg_ready=1.
  - io_locked=0, io_busy=0, io_err=0, io_relock_cnt=0.
  - All internal counters=0.
- States: IDLE, RESET, WAIT_LOCK, LOCKED, ERROR.
- io_cfg_ready: 1 in IDLE, LOCKED and ERROR; 0 in RESET and WAIT_LOCK. A request is accepted only on valid&&ready in the same cycle.
- Illegal cfg (madj==0):
  - Accepted (ready drops for 0 cycles), sets io_err, state goes to ERROR.
  - io_adj and io_madj are unchanged; io_dll_reset is driven to 1.
- Legal cfg: io_err cleared and retry counter cleared on the next cycle.
  - From IDLE or ERROR, or when madj differs from current io_madj: go to RESET, with io_adj/io_madj registered the same edge.
  - From LOCKED with madj equal and adj different: io_adj updates, go to WAIT_LOCK directly, no DLL reset.
  - From LOCKED with cfg identical to current: stay LOCKED; the request is consumed with no change.
- RESET:
  - io_dll_reset=1 for exactly RST_CYCLES cycles (counter 0..RST_CYCLES-1).
  - Then io_dll_reset=0 and go to WAIT_LOCK.
- WAIT_LOCK:
  - Timer starts at 0 on entry; io_lock is ignored while timer<BLANK_CYCLES.
  - io_lock==1 after blanking: go to LOCKED next edge.
  - timer==LOCK_TIMEOUT-1 without lock, retry<MAX_RETRY: retry++ and go to RESET.
  - Same condition with retry==MAX_RETRY: go to ERROR with io_err=1 and io_dll_reset=1.
  - If lock arrives in the same cycle as the timeout, lock wins.
- LOCKED:
  - io_locked = io_lock registered, so it is 1 on the entry cycle.
  - io_lock falls with no accepted cfg: io_relock_cnt+1 (saturate at 255), go to WAIT_LOCK, retry cleared.
  - If a cfg accept and a lock fall happen in the same cycle, the cfg wins and the counter does not increment.
- ERROR: io_dll_reset=1; leaves only on a legal cfg.
- Status outputs are registered with no combinational path from io_lock to outputs, except io_cfg_ready, which is decoded from state.
- Counter widths are $clog2 of the largest of RST_CYCLES and LOCK_TIMEOUT, plus 1; the retry counter is $clog2(MAX_RETRY+1).
- reset_n assertion mid-sequence returns everything to reset values immediately, including io_dll_reset=1.

Decomposition:
- Package dll_ctrl_pkg:
  - State enum typedef (3-bit).
  - Localparams ADJ_W=8, default RST_CYCLES/LOCK_TIMEOUT.
  - Lock-time constant DLL_LOCK_CYCLES=100 for benches.
- One sub-module, dll_lock_timer: loadable up-counter with clear, blank-done and timeout-hit outputs. It is reused for the RESET hold and for WAIT_LOCK timing.
- FSM, cfg registers and status live in the top module.

Test Plan:
- Bring-up: release reset_n, send cfg adj=32 madj=128. Expect:
  - io_dll_reset high 16 cycles, then low.
  - io_locked=1 about 101–103 cycles later.
  - io_busy low, io_adj=32, io_madj=128.
- Adj retune: from LOCKED, cfg adj=64 madj=128. Expect:
  - No io_dll_reset pulse; io_adj=64 next edge.
  - io_locked drops, then returns after the DLL relock of about 100 cycles.
  - io_relock_cnt stays 0.
- Timeout/retry: bench DLL model never locks, with LOCK_TIMEOUT=255 and MAX_RETRY=3. Expect:
  - 4 RESET pulses, then ERROR with io_err=1, io_dll_reset=1, io_cfg_ready=1.
  - A subsequent legal cfg clears io_err.
- Illegal cfg: cfg madj=0 while LOCKED. Expect io_err=1, ERROR, io_madj unchanged, io_dll_reset=1.
- Unsolicited loss: force io_lock low for 1 cycle in LOCKED. Expect io_relock_cnt=1, WAIT_LOCK with blanking honoured, relock. Repeat 300 times and expect the count to saturate at 255.
- Async reset mid-WAIT_LOCK: pull reset_n low between edges. Expect outputs at reset values immediately (io_dll_reset=1, io_adj=0, io_madj=1) and state IDLE.
